// File: rtl/usb_rx_decoder.sv
// Low-speed/full-speed USB receive path: NRZI decode, SYNC detect, bit unstuffing,
// byte assembly and EOP qualification, one bus bit-time per clock.
module usb_rx_decoder #(
  parameter int MAX_BYTES = 11
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       dp,
  input  logic       dm,
  input  logic       enable,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic [3:0] rx_pid,
  output logic       rx_active,
  output logic [3:0] byte_count,
  output logic       pkt_done,
  output logic       pkt_error
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP1,
    EOP2,
    WAIT_IDLE
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BYTES);

  state_t     state;
  logic       prev_j;
  logic [2:0] sync_cnt;
  logic [2:0] ones_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;

  logic       is_j;
  logic       is_k;
  logic       is_se0;
  logic       is_se1;
  logic       line_bit;
  logic [7:0] next_shift;

  assign is_j       = dp & ~dm;
  assign is_k       = ~dp & dm;
  assign is_se0     = ~dp & ~dm;
  assign is_se1     = dp & dm;
  // NRZI: no transition decodes as 1
  assign line_bit   = ~(is_j ^ prev_j);
  assign next_shift = {line_bit, shift[7:1]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      prev_j        <= 1'b1;
      sync_cnt      <= 3'd0;
      ones_cnt      <= 3'd0;
      bit_cnt       <= 3'd0;
      shift         <= 8'h00;
      rx_byte       <= 8'h00;
      rx_byte_valid <= 1'b0;
      rx_pid        <= 4'h0;
      rx_active     <= 1'b0;
      byte_count    <= 4'd0;
      pkt_done      <= 1'b0;
      pkt_error     <= 1'b0;
    end else begin
      rx_byte_valid <= 1'b0;
      pkt_done      <= 1'b0;
      pkt_error     <= 1'b0;
      if (!enable) begin
        state     <= IDLE;
        prev_j    <= 1'b1;
        rx_active <= 1'b0;
        bit_cnt   <= 3'd0;
        ones_cnt  <= 3'd0;
        shift     <= 8'h00;
      end else begin
        case (state)
          IDLE: begin
            prev_j <= 1'b1;
            if (is_k) begin
              state      <= SYNC;
              prev_j     <= 1'b0;
              sync_cnt   <= 3'd1;
              byte_count <= 4'd0;
              rx_pid     <= 4'h0;
            end
          end
          SYNC: begin
            if (is_se0 || is_se1) begin
              pkt_error <= 1'b1;
              state     <= WAIT_IDLE;
            end else begin
              prev_j <= is_j;
              if (!line_bit && sync_cnt != 3'd7) begin
                sync_cnt <= sync_cnt + 3'd1;
              end else if (line_bit && sync_cnt == 3'd7) begin
                state     <= DATA;
                rx_active <= 1'b1;
                bit_cnt   <= 3'd0;
                ones_cnt  <= 3'd0;
                shift     <= 8'h00;
              end else begin
                pkt_error <= 1'b1;
                state     <= WAIT_IDLE;
              end
            end
          end
          DATA: begin
            if (is_se1) begin
              pkt_error <= 1'b1;
              rx_active <= 1'b0;
              state     <= WAIT_IDLE;
            end else if (is_se0) begin
              state <= EOP1;
            end else begin
              prev_j <= is_j;
              // after six 1s the next bit must be a stuffed 0, which is dropped
              if (ones_cnt == 3'd6) begin
                if (line_bit) begin
                  pkt_error <= 1'b1;
                  rx_active <= 1'b0;
                  state     <= WAIT_IDLE;
                end else begin
                  ones_cnt <= 3'd0;
                end
              end else begin
                ones_cnt <= line_bit ? ones_cnt + 3'd1 : 3'd0;
                shift    <= next_shift;
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  if (byte_count == MAX_CNT) begin
                    pkt_error <= 1'b1;
                    rx_active <= 1'b0;
                    state     <= WAIT_IDLE;
                  end else begin
                    rx_byte       <= next_shift;
                    rx_byte_valid <= 1'b1;
                    byte_count    <= byte_count + 4'd1;
                    if (byte_count == 4'd0) begin
                      rx_pid <= next_shift[3:0];
                      if (next_shift[7:4] != ~next_shift[3:0]) begin
                        pkt_error <= 1'b1;
                        rx_active <= 1'b0;
                        state     <= WAIT_IDLE;
                      end
                    end
                  end
                end
              end
            end
          end
          EOP1: begin
            if (is_se0) begin
              state <= EOP2;
            end else begin
              pkt_error <= 1'b1;
              rx_active <= 1'b0;
              state     <= WAIT_IDLE;
            end
          end
          EOP2: begin
            if (is_j) begin
              state     <= IDLE;
              prev_j    <= 1'b1;
              rx_active <= 1'b0;
              if (bit_cnt == 3'd0 && byte_count != 4'd0) begin
                pkt_done <= 1'b1;
              end else begin
                pkt_error <= 1'b1;
              end
            end else begin
              pkt_error <= 1'b1;
              rx_active <= 1'b0;
              state     <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            rx_active <= 1'b0;
            if (is_j) begin
              state  <= IDLE;
              prev_j <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Self-checking bench for usb_rx_decoder: NRZI/bit-stuffing packet encoder, table of
// packets with expected results, byte scoreboard, plus reset/enable abort sequences.
module tb_usb_rx_decoder;

  localparam logic [1:0] SJ  = 2'b10;
  localparam logic [1:0] SK  = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       dp = 1'b1;
  logic       dm = 1'b0;
  logic       enable = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic [3:0] rx_pid;
  logic       rx_active;
  logic [3:0] byte_count;
  logic       pkt_done;
  logic       pkt_error;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  int err_seen = 0;
  logic [7:0] exp_q[$];

  bit level = 1'b1;
  int ones = 0;

  typedef struct {
    string       name;
    int          n;
    logic [95:0] data;
    bit          stuff;
    bit          eop_short;
    int          extra;
    logic [7:0]  extra_bits;
    int          exp_valid;
    int          exp_count;
    int          exp_pid;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];

  usb_rx_decoder #(.MAX_BYTES(11)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .dp            (dp),
    .dm            (dm),
    .enable        (enable),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .rx_pid        (rx_pid),
    .rx_active     (rx_active),
    .byte_count    (byte_count),
    .pkt_done      (pkt_done),
    .pkt_error     (pkt_error)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard: every delivered byte must match the oldest expected byte
  always @(negedge clock) begin
    if (rx_byte_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected: got 0x%0h expected no byte", rx_byte);
      end else begin
        checkOutput("sb_byte", int'(rx_byte), int'(exp_q.pop_front()));
      end
    end
    if (pkt_done) done_seen++;
    if (pkt_error) err_seen++;
    if (pkt_done && pkt_error) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_and_error: got both high expected at most one");
    end
  end

  task automatic applyStimulus(input logic [1:0] sym);
    {dp, dm} = sym;
    @(posedge clock);
    #1;
  endtask

  task automatic sendRaw(input bit b);
    if (!b) level = ~level;
    applyStimulus(level ? SJ : SK);
  endtask

  task automatic sendBit(input bit b, input bit stuff_en);
    if (stuff_en && ones == 6) begin
      sendRaw(1'b0);
      ones = 0;
    end
    sendRaw(b);
    ones = b ? ones + 1 : 0;
  endtask

  task automatic sendSync();
    level = 1'b1;
    ones = 0;
    for (int i = 0; i < 7; i++) sendRaw(1'b0);
    sendRaw(1'b1);
    checkOutput("sync_active", int'(rx_active), 1);
  endtask

  task automatic sendPacket(input int idx);
    vec_t v;
    logic [7:0] b;
    v = vecs[idx];
    done_seen = 0;
    err_seen = 0;
    sendSync();
    for (int i = 0; i < v.n; i++) begin
      b = v.data[i*8 +: 8];
      if (i < v.exp_valid) exp_q.push_back(b);
      for (int k = 0; k < 8; k++) sendBit(b[k], v.stuff);
      checkOutput({v.name, "_valid"}, int'(rx_byte_valid), (i < v.exp_valid) ? 1 : 0);
    end
    for (int k = 0; k < v.extra; k++) sendBit(v.extra_bits[k], v.stuff);
    applyStimulus(SE0);
    if (!v.eop_short) applyStimulus(SE0);
    applyStimulus(SJ);
    level = 1'b1;
    checkOutput({v.name, "_done_now"}, int'(pkt_done), int'(v.exp_done));
    repeat (3) applyStimulus(SJ);
    checkOutput({v.name, "_done_cnt"}, done_seen, int'(v.exp_done));
    checkOutput({v.name, "_err_cnt"}, err_seen, int'(v.exp_err));
    checkOutput({v.name, "_count"}, int'(byte_count), v.exp_count);
    checkOutput({v.name, "_pid"}, int'(rx_pid), v.exp_pid);
    checkOutput({v.name, "_active"}, int'(rx_active), 0);
    checkOutput({v.name, "_queue"}, exp_q.size(), 0);
  endtask

  task automatic setVec(input int idx, input string name, input int n, input logic [95:0] data,
                        input bit stuff, input bit eop_short, input int extra,
                        input logic [7:0] extra_bits, input int exp_valid, input int exp_count,
                        input int exp_pid, input bit exp_done, input bit exp_err);
    vecs[idx].name       = name;
    vecs[idx].n          = n;
    vecs[idx].data       = data;
    vecs[idx].stuff      = stuff;
    vecs[idx].eop_short  = eop_short;
    vecs[idx].extra      = extra;
    vecs[idx].extra_bits = extra_bits;
    vecs[idx].exp_valid  = exp_valid;
    vecs[idx].exp_count  = exp_count;
    vecs[idx].exp_pid    = exp_pid;
    vecs[idx].exp_done   = exp_done;
    vecs[idx].exp_err    = exp_err;
  endtask

  initial begin
    logic [7:0] b;
    setVec(0, "ack",      1,  96'hD2,                       1, 0, 0, 8'h00, 1,  1,  2, 1, 0);
    setVec(1, "out",      3,  96'h1D05E1,                   1, 0, 0, 8'h00, 3,  3,  1, 1, 0);
    setVec(2, "stuffed",  3,  96'hFFFFC3,                   1, 0, 0, 8'h00, 3,  3,  3, 1, 0);
    setVec(3, "nostuff",  3,  96'hFFFFC3,                   0, 0, 0, 8'h00, 1,  1,  3, 0, 1);
    setVec(4, "badpid",   1,  96'hD3,                       1, 0, 0, 8'h00, 1,  1,  3, 0, 1);
    setVec(5, "shorteop", 1,  96'hD2,                       1, 1, 0, 8'h00, 1,  1,  2, 0, 1);
    setVec(6, "partial",  1,  96'hD2,                       1, 0, 4, 8'h05, 1,  1,  2, 0, 1);
    setVec(7, "overflow", 12, 96'h0B0A090807060504030201C3, 1, 0, 0, 8'h00, 11, 11, 3, 0, 1);

    {dp, dm} = SJ;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_byte", int'(rx_byte), 0);
    checkOutput("rst_valid", int'(rx_byte_valid), 0);
    checkOutput("rst_pid", int'(rx_pid), 0);
    checkOutput("rst_active", int'(rx_active), 0);
    checkOutput("rst_count", int'(byte_count), 0);
    checkOutput("rst_done", int'(pkt_done), 0);
    checkOutput("rst_error", int'(pkt_error), 0);
    reset_n = 1'b1;
    repeat (3) applyStimulus(SJ);

    for (int i = 0; i < 8; i++) sendPacket(i);

    // Asynchronous reset in the middle of the second byte
    done_seen = 0;
    err_seen = 0;
    sendSync();
    b = 8'hE1;
    exp_q.push_back(b);
    for (int k = 0; k < 8; k++) sendBit(b[k], 1'b1);
    sendBit(1'b1, 1'b1);
    sendBit(1'b0, 1'b1);
    sendBit(1'b1, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrst_active", int'(rx_active), 0);
    checkOutput("midrst_count", int'(byte_count), 0);
    checkOutput("midrst_pid", int'(rx_pid), 0);
    checkOutput("midrst_byte", int'(rx_byte), 0);
    {dp, dm} = SJ;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    level = 1'b1;
    repeat (3) applyStimulus(SJ);
    checkOutput("midrst_done", done_seen, 0);
    checkOutput("midrst_err", err_seen, 0);
    checkOutput("midrst_queue", exp_q.size(), 0);
    sendPacket(0);

    // Enable dropped in the middle of the second byte
    done_seen = 0;
    err_seen = 0;
    sendSync();
    b = 8'hD2;
    exp_q.push_back(b);
    for (int k = 0; k < 8; k++) sendBit(b[k], 1'b1);
    sendBit(1'b0, 1'b1);
    sendBit(1'b1, 1'b1);
    sendBit(1'b0, 1'b1);
    enable = 1'b0;
    applyStimulus(SJ);
    checkOutput("dis_active", int'(rx_active), 0);
    applyStimulus(SK);
    applyStimulus(SJ);
    enable = 1'b1;
    level = 1'b1;
    repeat (3) applyStimulus(SJ);
    checkOutput("dis_done", done_seen, 0);
    checkOutput("dis_err", err_seen, 0);
    checkOutput("dis_active2", int'(rx_active), 0);
    sendPacket(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_rx_decoder.md
USB_RX_DECODER -- requirements
Module: usb_rx_decoder

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 11, meaning the maximum number of bytes (PID included) accepted per packet.
REQ-002 SHALL have port clock, input, 1, system clock; one bus bit-time per clock.
REQ-003 SHALL have port reset_n, input, 1; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port dp, input, 1, sampled D+ line.
REQ-005 SHALL have port dm, input, 1, sampled D- line.
REQ-006 SHALL have port enable, input, 1; high while the host is not driving and is listening.
REQ-007 SHALL have port rx_byte, output, 8, last assembled byte, LSB-first bit order.
REQ-008 SHALL have port rx_byte_valid, output, 1; one-cycle pulse qualifying rx_byte.
REQ-009 SHALL have port rx_pid, output, 4, low nibble of the first byte of the current or last packet.
REQ-010 SHALL have port rx_active, output, 1; high from SYNC completion through the end of packet.
REQ-011 SHALL have port byte_count, output, 4, number of bytes delivered in the current or last packet.
REQ-012 SHALL have port pkt_done, output, 1; one-cycle pulse on a good EOP.
REQ-013 SHALL have port pkt_error, output, 1; one-cycle pulse on any error.

Function
REQ-014 SHALL decode bus states from {dp,dm}: J=10, K=01, SE0=00, SE1=11; idle is J.
REQ-015 SHALL NRZI-decode each J/K sample: bit=1 if the level equals the previous level, else 0; the previous level is J after reset and after each return to IDLE.
REQ-016 SHALL implement states IDLE, SYNC, DATA, EOP1, EOP2, WAIT_IDLE.
REQ-017 IDLE: on a K sample with enable=1, SHALL go to SYNC; that sample counts as the first decoded SYNC bit (0).
REQ-018 SYNC: SHALL require decoded bits 0000000 then 1, LSB-first (bus KJKJKJKK); on the final 1 it SHALL go to DATA and assert rx_active the next cycle; any other bit or SE0/SE1 SHALL raise pkt_error and go to WAIT_IDLE.
REQ-019 DATA: SHALL count consecutive decoded 1s; after six 1s the next bit SHALL be discarded if 0 (stuff bit); if 1 it SHALL raise pkt_error (stuff error); a 0 or a stuff bit SHALL clear the count.
REQ-020 DATA: SHALL shift non-stuff bits LSB-first; on the 8th bit, rx_byte SHALL update and rx_byte_valid SHALL pulse for one cycle, on the clock edge after the 8th bit is sampled (latency 1); byte_count SHALL increment with the same timing.
REQ-021 The first byte of a packet SHALL load rx_pid with bits[3:0]; if bits[7:4] != ~bits[3:0], the byte SHALL still be delivered and pkt_error SHALL pulse, followed by WAIT_IDLE.
REQ-022 If byte MAX_BYTES+1 completes, the block SHALL NOT deliver that byte; it SHALL raise pkt_error and go to WAIT_IDLE.
REQ-023 DATA with SE0 SHALL go to EOP1; EOP1 with SE0 SHALL go to EOP2; EOP2 with J SHALL pulse pkt_done, drop rx_active and go to IDLE, provided the bit count within the current byte is 0 and byte_count>=1; otherwise it SHALL pulse pkt_error.
REQ-024 EOP1 with a non-SE0 sample, or EOP2 with K/SE0/SE1, SHALL raise pkt_error and go to WAIT_IDLE.
REQ-025 SE1 in any state except IDLE/WAIT_IDLE SHALL raise pkt_error and go to WAIT_IDLE.
REQ-026 WAIT_IDLE SHALL ignore the bus until a J sample and then go to IDLE; rx_active SHALL be 0 in WAIT_IDLE.
REQ-027 enable=0 in any state SHALL go to IDLE on the next edge, clear rx_active and the partial byte, and SHALL NOT pulse pkt_done or pkt_error.
REQ-028 pkt_done and pkt_error SHALL never assert in the same cycle; at most one error pulse SHALL occur per packet.
REQ-029 byte_count and rx_pid SHALL clear on SYNC entry and hold after packet end.

Reset
REQ-030 reset_n=0 SHALL immediately force IDLE, previous level=J, and all outputs to 0 (rx_byte=8'h00, rx_pid=4'h0, byte_count=0), including mid-packet; no pulse SHALL follow reset release.

Verification
REQ-031 ACK: SYNC + PID 8'hD2 + SE0,SE0,J -> one rx_byte_valid with 8'hD2, rx_pid=4'h2, byte_count=1, pkt_done one cycle after the J.
REQ-032 OUT token 8'hE1, 8'h05, 8'h1D -> three valid pulses in order, byte_count=3, pkt_done, no pkt_error.
REQ-033 DATA0 8'hC3 followed by 8'hFF,8'hFF with stuff bits inserted -> bytes C3,FF,FF delivered, no error; the same packet without stuffing -> pkt_error at the 7th one.
REQ-034 PID 8'hD3 -> byte delivered, pkt_error pulse, WAIT_IDLE until J, no pkt_done.
REQ-035 Single-cycle SE0 then J, or EOP after 12 bits -> pkt_error; 12 bytes with MAX_BYTES=11 -> 11 valid pulses then pkt_error.
REQ-036 reset_n low mid-DATA, or enable low mid-DATA -> IDLE, rx_active=0, no pulses; the next clean ACK packet decodes correctly.
